// File: rtl/fadn_pipe.sv
// rtl/fadn_pipe.sv - pipelined WIDTH-bit adder/subtractor, one SEG-bit slice per stage
// Optional signed-overflow output enabled by defining FADN_OVF_EN.
module fadn_pipe #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             CK,
   input  logic             CDN,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CI,
   input  logic             SUB,
   input  logic             IN_VLD,
   output logic             IN_RDY,
   output logic [WIDTH-1:0] S,
   output logic             CO,
   output logic             OVF,
   output logic             OUT_VLD,
   input  logic             OUT_RDY
);

   localparam int STAGES = WIDTH / SEG;

   logic             stall;
   logic             in_fire;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   // Subtract is A + ~B + ~CI, so the borrow-in becomes an inverted carry-in.
   assign b_eff   = SUB ? ~B : B;
   assign c0      = SUB ? ~CI : CI;
   assign stall   = OUT_VLD & ~OUT_RDY;
   assign IN_RDY  = ~stall;
   assign in_fire = IN_VLD & IN_RDY;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int REM = WIDTH - k * SEG;

      logic [REM-1:0]       a_src;
      logic [REM-1:0]       b_src;
      logic                 c_src;
      logic                 v_src;
      logic [SEG:0]         add;
      logic [(k+1)*SEG-1:0] s_nxt;
      logic                 vld_q;
      logic                 c_q;
      logic [(k+1)*SEG-1:0] s_q;

      if (k == 0) begin : g_head
         assign a_src = A;
         assign b_src = b_eff;
         assign c_src = c0;
         assign v_src = in_fire;
         assign s_nxt = add[SEG-1:0];
      end else begin : g_link
         assign a_src = g_stage[k-1].g_skew.a_q;
         assign b_src = g_stage[k-1].g_skew.b_q;
         assign c_src = g_stage[k-1].c_q;
         assign v_src = g_stage[k-1].vld_q;
         assign s_nxt = {add[SEG-1:0], g_stage[k-1].s_q};
      end

      assign add = {1'b0, a_src[SEG-1:0]} + {1'b0, b_src[SEG-1:0]} + {{SEG{1'b0}}, c_src};

      // Data only loads behind a valid token, so bubbles leave the last result in place.
      always_ff @(posedge CK or negedge CDN) begin
         if (!CDN) begin
            vld_q <= 1'b0;
            c_q   <= 1'b0;
            s_q   <= '0;
         end else if (!stall) begin
            vld_q <= v_src;
            if (v_src) begin
               c_q <= add[SEG];
               s_q <= s_nxt;
            end
         end
      end

      if (k < STAGES - 1) begin : g_skew
         logic [REM-SEG-1:0] a_q;
         logic [REM-SEG-1:0] b_q;

         always_ff @(posedge CK or negedge CDN) begin
            if (!CDN) begin
               a_q <= '0;
               b_q <= '0;
            end else if (!stall && v_src) begin
               a_q <= a_src[REM-1:SEG];
               b_q <= b_src[REM-1:SEG];
            end
         end
      end
   end

   assign S       = g_stage[STAGES-1].s_q;
   assign CO      = g_stage[STAGES-1].c_q;
   assign OUT_VLD = g_stage[STAGES-1].vld_q;

`ifdef FADN_OVF_EN
   logic a_msb;
   logic b_msb;
   logic s_msb;
   logic ovf_q;

   assign a_msb = g_stage[STAGES-1].a_src[SEG-1];
   assign b_msb = g_stage[STAGES-1].b_src[SEG-1];
   assign s_msb = g_stage[STAGES-1].add[SEG-1];

   always_ff @(posedge CK or negedge CDN) begin
      if (!CDN) begin
         ovf_q <= 1'b0;
      end else if (!stall && g_stage[STAGES-1].v_src) begin
         ovf_q <= (a_msb == b_msb) & (s_msb != a_msb);
      end
   end

   assign OVF = ovf_q;
`else
   assign OVF = 1'b0;
`endif

endmodule

// File: tb/tb_fadn_pipe.sv
// tb/tb_fadn_pipe.sv - directed and streaming checks of fadn_pipe at 16/4, 8/8 and 32/4
`timescale 1ns/1ps
module tb_fadn_pipe;

`ifdef FADN_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic        CK = 1'b0;
   logic        CDN;
   logic [31:0] a32, b32;
   logic        CI, SUB, IN_VLD, OUT_RDY;

   logic        rdy16, co16, ovf16, vld16;
   logic [15:0] s16;
   logic        rdy8, co8, ovf8, vld8;
   logic [7:0]  s8;
   logic        rdy32, co32, ovf32, vld32;
   logic [31:0] s32;

   int checks   = 0;
   int failures = 0;
   int pops16, pops8, pops32;
   logic [33:0] q16[$];
   logic [33:0] q8[$];
   logic [33:0] q32[$];

   always #5 CK = ~CK;

   fadn_pipe #(.WIDTH(16), .SEG(4)) dut16 (
      .CK(CK), .CDN(CDN), .A(a32[15:0]), .B(b32[15:0]), .CI(CI), .SUB(SUB),
      .IN_VLD(IN_VLD), .IN_RDY(rdy16), .S(s16), .CO(co16), .OVF(ovf16),
      .OUT_VLD(vld16), .OUT_RDY(OUT_RDY)
   );

   fadn_pipe #(.WIDTH(8), .SEG(8)) dut8 (
      .CK(CK), .CDN(CDN), .A(a32[7:0]), .B(b32[7:0]), .CI(CI), .SUB(SUB),
      .IN_VLD(IN_VLD), .IN_RDY(rdy8), .S(s8), .CO(co8), .OVF(ovf8),
      .OUT_VLD(vld8), .OUT_RDY(OUT_RDY)
   );

   fadn_pipe #(.WIDTH(32), .SEG(4)) dut32 (
      .CK(CK), .CDN(CDN), .A(a32), .B(b32), .CI(CI), .SUB(SUB),
      .IN_VLD(IN_VLD), .IN_RDY(rdy32), .S(s32), .CO(co32), .OVF(ovf32),
      .OUT_VLD(vld32), .OUT_RDY(OUT_RDY)
   );

   // Whole-word reference: {ovf, co, sum} for a w-bit operation.
   function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic ci, input logic sub);
      logic [32:0] mask, aa, bb, sum;
      logic        co, ovf;
      mask = (33'd1 << w) - 33'd1;
      aa   = {1'b0, a} & mask;
      bb   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
      sum  = aa + bb + {32'd0, ci ^ sub};
      co   = sum[w];
      ovf  = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
      if (!OVF_ON) ovf = 1'b0;
      return {ovf, co, sum[31:0] & mask[31:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: score output transfers, record accepts, then advance to 1ns past the edge.
   task automatic step();
      logic [33:0] e;
      #1;
      if (vld16 && OUT_RDY) begin
         pops16++;
         if (q16.size() != 0) e = q16.pop_front(); else e = 'x;
         chk("out16", {30'd0, ovf16, co16, 16'd0, s16}, {30'd0, e});
      end
      if (vld8 && OUT_RDY) begin
         pops8++;
         if (q8.size() != 0) e = q8.pop_front(); else e = 'x;
         chk("out8", {30'd0, ovf8, co8, 24'd0, s8}, {30'd0, e});
      end
      if (vld32 && OUT_RDY) begin
         pops32++;
         if (q32.size() != 0) e = q32.pop_front(); else e = 'x;
         chk("out32", {30'd0, ovf32, co32, s32}, {30'd0, e});
      end
      if (IN_VLD && rdy16) q16.push_back(model(16, a32, b32, CI, SUB));
      if (IN_VLD && rdy8)  q8.push_back(model(8, a32, b32, CI, SUB));
      if (IN_VLD && rdy32) q32.push_back(model(32, a32, b32, CI, SUB));
      @(posedge CK);
      #1;
   endtask

   task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sub,
                         input logic [15:0] es, input logic eco, input logic eovf);
      int lat16, lat8, lat32;
      a32 = a; b32 = b; CI = ci; SUB = sub; IN_VLD = 1'b1; OUT_RDY = 1'b1;
      step();
      IN_VLD = 1'b0;
      lat16 = 0; lat8 = 0; lat32 = 0;
      for (int n = 1; n <= 12; n++) begin
         if (vld8 && lat8 == 0) lat8 = n;
         if (vld32 && lat32 == 0) lat32 = n;
         if (vld16 && lat16 == 0) begin
            lat16 = n;
            chk({tag, "_s"}, s16, es);
            chk({tag, "_co"}, co16, eco);
            chk({tag, "_ovf"}, ovf16, eovf);
         end
         step();
      end
      chk({tag, "_lat16"}, lat16, 4);
      chk({tag, "_lat8"}, lat8, 1);
      chk({tag, "_lat32"}, lat32, 8);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      CDN = 1'b0; a32 = '0; b32 = '0; CI = 1'b0; SUB = 1'b0; IN_VLD = 1'b0; OUT_RDY = 1'b1;
      pops16 = 0; pops8 = 0; pops32 = 0;
      repeat (3) @(posedge CK);
      #1;
      chk("rst_vld16", vld16, 0);
      chk("rst_s16", s16, 0);
      chk("rst_co16", co16, 0);
      chk("rst_ovf16", ovf16, 0);
      chk("rst_rdy16", rdy16, 1);
      chk("rst_vld8", vld8, 0);
      chk("rst_vld32", vld32, 0);
      CDN = 1'b1;

      single("ripple",  32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      single("ovf_add", 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF_ON);
      single("sub",     32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      single("sub_ovf", 32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, OVF_ON);
      single("sub_bi",  32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);

      pops16 = 0; pops8 = 0; pops32 = 0;
      OUT_RDY = 1'b1;
      for (int i = 0; i < 100; i++) begin
         a32 = $urandom; b32 = $urandom;
         CI = 1'($urandom_range(0, 1)); SUB = 1'($urandom_range(0, 1));
         IN_VLD = 1'b1;
         step();
      end
      chk("tput16", pops16, 96);
      chk("tput8", pops8, 99);
      chk("tput32", pops32, 92);
      IN_VLD = 1'b0;
      repeat (12) step();
      chk("drain16", q16.size(), 0);
      chk("drain8", q8.size(), 0);
      chk("drain32", q32.size(), 0);

      for (int i = 0; i < 6; i++) begin
         a32 = $urandom; b32 = $urandom;
         CI = 1'($urandom_range(0, 1)); SUB = 1'($urandom_range(0, 1));
         IN_VLD = 1'b1;
         step();
      end
      OUT_RDY = 1'b0;
      for (int j = 0; j < 5; j++) begin
         a32 = $urandom; b32 = $urandom;
         IN_VLD = 1'b1;
         #1;
         chk("bp_rdy16", rdy16, 0);
         chk("bp_vld16", vld16, 1);
         chk("bp_out16", {30'd0, ovf16, co16, 16'd0, s16}, {30'd0, q16[0]});
         chk("bp_fill16", q16.size(), 4);
         step();
      end
      OUT_RDY = 1'b1;
      IN_VLD = 1'b0;
      repeat (12) step();
      chk("bp_drain16", q16.size(), 0);
      chk("bp_drain8", q8.size(), 0);
      chk("bp_drain32", q32.size(), 0);

      single("add_ci", 32'h0000_1234, 32'h0000_4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
      chk("hold_s16", s16, 16'h5556);
      chk("hold_vld16", vld16, 0);

      for (int i = 0; i < 3; i++) begin
         a32 = $urandom; b32 = $urandom;
         IN_VLD = 1'b1;
         step();
      end
      IN_VLD = 1'b0;
      #2;
      CDN = 1'b0;
      #1;
      chk("mid_rst_vld16", vld16, 0);
      chk("mid_rst_s16", s16, 0);
      chk("mid_rst_co16", co16, 0);
      chk("mid_rst_ovf16", ovf16, 0);
      chk("mid_rst_rdy16", rdy16, 1);
      chk("mid_rst_vld8", vld8, 0);
      chk("mid_rst_s8", s8, 0);
      q16.delete(); q8.delete(); q32.delete();
      @(posedge CK);
      #1;
      CDN = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("stale_vld16", vld16, 0);
         chk("stale_vld32", vld32, 0);
         step();
      end
      single("post_rst", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fadn_pipe.md
# fadn_pipe

Parametrised, pipelined N-bit full adder/subtractor for the ECP simulation library. It is the successor to the fixed 4-bit ripple adder cells. The operand width is split into SEG-bit slices, and each slice is added in its own register stage, with the carry registered between stages. The block has a valid/ready handshake and a mode-selectable subtract, and sits on datapaths where a wide combinational carry chain would limit clock frequency.

## Interface
- WIDTH, 16, operand and sum width in bits; must be an exact multiple of SEG, and ≥ SEG.
- SEG, 4, slice width added per pipeline stage; STAGES = WIDTH/SEG (derived, not overridable).
- CK  input  1  rising-edge clock; the only clock.
- CDN  input  1  asynchronous, active-low reset; clears all state immediately, released synchronously to CK by the system.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CI  input  1  carry-in (SUB=0) or borrow-in (SUB=1).
- SUB  input  1  0: S = A + B + CI; 1: S = A − B − CI.
- IN_VLD  input  1  input transfer request.
- IN_RDY  output  1  block can accept input this cycle.
- S  output  WIDTH  registered result.
- CO  output  1  carry-out (SUB=0) or not-borrow (SUB=1).
- OVF  output  1  two's-complement signed overflow of the result.
- OUT_VLD  output  1  S/CO/OVF hold a valid result.
- OUT_RDY  input  1  downstream accepts the result.

## Operation
- Internally, the operation is A + B' + C0, where:
  - SUB=0: B' = B and C0 = CI.
  - SUB=1: B' = ~B and C0 = ~CI.
- Stage k (k = 0..STAGES−1) adds slice k of A and B', plus the carry registered by stage k−1 (C0 for stage 0).
  - It writes sum slice k into the result shift register.
  - Higher slices of A and B' travel down the pipe in skew registers.
- Each stage holds a valid bit. Stage valids form a shift chain fed by (IN_VLD & IN_RDY).
- Stall = OUT_VLD & ~OUT_RDY. While stalled, every stage register, including the skew and carry registers, holds its value.
- IN_RDY = ~Stall (combinational from OUT_VLD and OUT_RDY).
- Bubbles are not collapsed: an invalid stage advances like a valid one when there is no stall.
- Final stage outputs:
  - S = all slices.
  - CO = carry out of the top slice.
  - OVF = (A[MSB] == B'[MSB]) & (S[MSB] != A[MSB]), using the A and B' MSBs carried in the skew registers.
- Arithmetic wraps modulo 2^WIDTH. The MSB carry is reported only on CO and is never folded back into S.
- Reset values:
  - S = 0, CO = 0, OVF = 0, OUT_VLD = 0.
  - All stage valids, carries and skew registers = 0.
  - IN_RDY = 1 (follows from OUT_VLD = 0).
- Reset mid-operation discards all in-flight transfers. No partial result is ever presented.
- Stage registers without valid data may hold any value. Outputs are defined only when OUT_VLD=1; while OUT_VLD=0, S/CO/OVF keep their last value.

## Timing
- Latency is STAGES rising edges from the accepting edge to OUT_VLD=1, with no stall (4 for the defaults).
- Throughput is one transfer per cycle when OUT_RDY=1 continuously.
- An output transfer occurs on an edge with OUT_VLD & OUT_RDY. The next result, if any, appears on that same edge.
- Simultaneous output transfer and input acceptance on one edge is legal and loses no data.
- While stalled, S/CO/OVF/OUT_VLD are stable and IN_RDY=0. An IN_VLD asserted during a stall is not accepted.
- The CDN assert takes effect without a CK edge. The first acceptance is possible on the first CK edge after CDN deasserts.
- Degenerate case WIDTH == SEG: a single stage with latency 1.

## Configuration
- FADN_OVF_EN defined: OVF is computed as above, and the MSB skew registers are kept.
- FADN_OVF_EN undefined:
  - OVF is driven constant 0.
  - MSB sign-tracking logic is omitted.
  - All other behaviour and timing are identical.

## Test plan
Defaults WIDTH=16, SEG=4, FADN_OVF_EN defined, unless stated.
- Reset: assert CDN low mid-stream with 3 transfers in flight → OUT_VLD=0, S=0, CO=0, OVF=0 immediately; IN_RDY=1; no stale result after release.
- Add with carry ripple across all slices: A=16'hFFFF, B=16'h0001, CI=0, SUB=0 → 4 edges later S=16'h0000, CO=1, OVF=0.
- Signed overflow and subtract:
  - A=16'h7FFF, B=16'h0001, SUB=0 → S=16'h8000, OVF=1, CO=0.
  - A=16'h0005, B=16'h0007, CI=0, SUB=1 → S=16'hFFFE, CO=0, OVF=0.
- Back-to-back streaming: 100 random transfers with IN_VLD=1 and OUT_RDY=1 → one result per cycle in order, each matching the reference model; first result 4 edges after the first accept.
- Backpressure: OUT_RDY=0 for 5 cycles with a full pipe → IN_RDY=0, outputs frozen; after OUT_RDY=1, results resume in order with none lost or duplicated.
- Configuration sweep: repeat the streaming test at WIDTH=8/SEG=8 (latency 1), WIDTH=32/SEG=4 (latency 8), and with FADN_OVF_EN undefined → OVF stays 0; S and CO are unchanged.
